// File: rtl/expr_emitter.sv
// ASCII expression serialiser: emits "d op d ... d" one byte per valid/ready beat.
// Optional stream self-check enabled by defining EXPR_EMIT_SELFCHECK_EN.
module expr_emitter #(
  parameter int MAX_TERMS = 8
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic [3:0]                   n_terms,
  input  logic [4*MAX_TERMS-1:0]       digits,
  input  logic [2*(MAX_TERMS-1)-1:0]   ops,
  output logic [7:0]                   out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam logic [3:0] MAX_N = 4'(MAX_TERMS);

  typedef enum logic [1:0] {S_IDLE, S_DIG, S_OP, S_FIN} state_e;

  state_e                          state_q, state_d;
  logic [3:0]                      idx_q, idx_d;
  logic [3:0]                      n_q, n_d;
  logic [MAX_TERMS-1:0][3:0]       digits_q, digits_d;
  logic [MAX_TERMS-2:0][1:0]       ops_q, ops_d;
  logic                            err_q, err_d;

  logic [3:0] cur_digit;
  logic [1:0] cur_op;
  logic       is_last;
  logic       legal;
  logic       accept;
  logic       chk_err;

  assign legal   = (n_terms != 4'd0) && (n_terms <= MAX_N);
  assign is_last = (idx_q == n_q - 4'd1);
  assign accept  = out_valid && out_ready;
  assign err     = err_q;

  // Operand/operator select for the current index
  always_comb begin
    cur_digit = '0;
    cur_op    = '0;
    for (int i = 0; i < MAX_TERMS; i++)
      if (idx_q == 4'(i)) cur_digit = digits_q[i];
    for (int i = 0; i < MAX_TERMS-1; i++)
      if (idx_q == 4'(i)) cur_op = ops_q[i];
  end

  // Output decode depends only on registered state, so it holds under stall
  always_comb begin
    out       = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_DIG: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = is_last;
        out       = (cur_digit > 4'd9) ? 8'h39 : 8'h30 + {4'h0, cur_digit};
      end
      S_OP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        case (cur_op)
          2'b00:   out = 8'h2B;
          2'b01:   out = 8'h2D;
          2'b10:   out = 8'h2A;
          default: out = 8'h2F;
        endcase
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

`ifdef EXPR_EMIT_SELFCHECK_EN
  logic       want_digit_q, want_digit_d;
  logic [4:0] cnt_q, cnt_d;
  logic       is_dig;

  // Mirror of the recogniser: digit first, then alternate, ending on a digit
  always_comb begin
    want_digit_d = want_digit_q;
    cnt_d        = cnt_q;
    chk_err      = 1'b0;
    is_dig       = (out >= 8'h30) && (out <= 8'h39);
    if (state_q == S_IDLE && start && legal) begin
      want_digit_d = 1'b1;
      cnt_d        = '0;
    end else if (accept) begin
      if (is_dig != want_digit_q) chk_err = 1'b1;
      want_digit_d = !want_digit_q;
      cnt_d        = cnt_q + 5'd1;
    end
    if (state_q == S_FIN && (cnt_q != {n_q, 1'b0} - 5'd1 || want_digit_q))
      chk_err = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      want_digit_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      want_digit_q <= want_digit_d;
      cnt_q        <= cnt_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    err_d    = err_q | chk_err;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            digits_d = digits;
            ops_d    = ops;
            n_d      = n_terms;
            idx_d    = '0;
            err_d    = 1'b0;
            state_d  = S_DIG;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DIG: begin
        if (cur_digit > 4'd9) err_d = 1'b1;
        if (accept) state_d = is_last ? S_FIN : S_OP;
      end
      S_OP: begin
        if (accept) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_DIG;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      digits_q <= digits_d;
      ops_q    <= ops_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_expr_emitter.sv
// Randomised bench for expr_emitter against a byte-queue reference model.
module tb_expr_emitter;
  localparam int MT = 8;

  logic                  clk = 1'b0;
  logic                  clr = 1'b1;
  logic                  start = 1'b0;
  logic [3:0]            n_terms = '0;
  logic [4*MT-1:0]       digits = '0;
  logic [2*(MT-1)-1:0]   ops = '0;
  logic [7:0]            out;
  logic                  out_valid, out_ready = 1'b0, out_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  expr_emitter #(.MAX_TERMS(MT)) dut (
    .clk(clk), .clr(clr), .start(start), .n_terms(n_terms), .digits(digits),
    .ops(ops), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always 1, mode 1: random ready + random start noise, mode 2: 1,0,0 pattern
  task automatic run_req(input int n, input logic [4*MT-1:0] d,
                         input logic [2*(MT-1)-1:0] o, input int mode);
    logic [7:0] opc [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    logic [7:0] exp_q [$];
    logic [7:0] held;
    logic [3:0] dv;
    bit   exp_err = 0;
    bit   stalled = 0;
    bit   fin = 0;
    bit   rdy;
    int   pos = 0;
    int   k = 0;
    for (int i = 0; i < n; i++) begin
      dv = d[4*i +: 4];
      if (dv > 9) begin exp_q.push_back(8'h39); exp_err = 1; end
      else exp_q.push_back(8'h30 + 8'(dv));
      if (i < n-1) exp_q.push_back(opc[o[2*i +: 2]]);
    end
    @(negedge clk);
    start = 1; n_terms = 4'(n); digits = d; ops = o;
    @(negedge clk);
    start = 0;
    n_terms = 4'($urandom); digits = {$urandom, $urandom}; ops = 14'($urandom);
    check("err_cleared", err, 0);
    while (!fin && k < 200) begin
      check("out_valid", out_valid, 1);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("out", out, exp_q[pos]);
      check("out_last", out_last, (pos == exp_q.size()-1));
      if (stalled) check("hold", out, held);
      case (mode)
        0:       rdy = 1;
        1:       rdy = $urandom_range(0, 1) == 1;
        default: rdy = (k % 3 == 0);
      endcase
      out_ready = rdy;
      if (mode == 1) begin start = $urandom_range(0, 1) == 1; n_terms = 4'($urandom); end
      held = out;
      stalled = !rdy;
      if (rdy) pos++;
      if (pos == exp_q.size()) fin = 1;
      @(negedge clk);
      k++;
    end
    start = 0;
    if (!fin) check("timeout", 0, 1);
    check("done_pulse", done, 1);
    check("fin_busy", busy, 0);
    check("fin_valid", out_valid, 0);
    check("err", err, exp_err);
    @(negedge clk);
    check("done_once", done, 0);
    check("idle_valid", out_valid, 0);
  endtask

  task automatic bad_req(input int n);
    @(negedge clk);
    start = 1; n_terms = 4'(n);
    @(negedge clk);
    start = 0;
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("bad_valid", out_valid, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [4*MT-1:0]     d;
    logic [2*(MT-1)-1:0] o;
    int                  n;
    #2;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    clr = 0;

    run_req(1, 32'h7, '0, 0);
    run_req(3, 32'h952, 14'b10_00, 0);
    run_req(3, 32'h952, 14'b10_00, 2);
    bad_req(0);
    bad_req(MT+1);
    run_req(2, 32'h41, 14'b01, 0);
    run_req(2, 32'hC3, 14'b00, 0);
    run_req(2, 32'h11, 14'b11, 2);

    // abort after two accepted bytes
    @(negedge clk);
    start = 1; n_terms = 4; digits = 32'h4321; ops = 14'b11_10_01; out_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    clr = 1;
    #1;
    check("clr_out", out, 0);
    check("clr_valid", out_valid, 0);
    check("clr_last", out_last, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_err", err, 0);
    @(negedge clk);
    clr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_no_done", done, 0);
      check("clr_idle", out_valid, 0);
    end
    run_req(4, 32'h4321, 14'b11_10_01, 0);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, MT);
      for (int i = 0; i < MT; i++)
        d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      o = 14'($urandom);
      run_req(n, d, o, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
